// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin dual-write / quad-read register file port arbiter with bounded write bursts.
// Define REGFILE_ARB_PERF_EN to add the saturating conflict and read-stall counters.
module regfile_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW = 5,
    parameter int DW = 64,
    parameter int MAX_WR_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    wr_req,
    input  logic [NREQ*AW-1:0] wr_addr,
    input  logic [NREQ*DW-1:0] wr_data,
    output logic [NREQ-1:0]    wr_gnt,
    input  logic               rd_req,
    input  logic [4*AW-1:0]    rd_addr,
    output logic               rd_gnt,
    output logic               rd_valid,
    output logic               rf_w,
    output logic               rf_r,
    output logic [AW-1:0]      rf_write_port,
    output logic [AW-1:0]      rf_write_port2,
    output logic [DW-1:0]      rf_in1,
    output logic [DW-1:0]      rf_in2,
    output logic [AW-1:0]      rf_read_port1,
    output logic [AW-1:0]      rf_read_port2,
    output logic [AW-1:0]      rf_read_port3,
    output logic [AW-1:0]      rf_read_port4
`ifdef REGFILE_ARB_PERF_EN
    ,
    output logic [15:0]        perf_conflict_cnt,
    output logic [15:0]        perf_rd_stall_cnt
`endif
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = $clog2(MAX_WR_BURST + 1);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    state_t state, nxt;
    logic [PW-1:0] rr_ptr, rr_nxt, idx, a_idx, b_idx;
    logic [SW-1:0] wr_streak;
    logic found_a, found_b;
    logic [NREQ-1:0] gnt;
`ifdef REGFILE_ARB_PERF_EN
    logic conflict;
`endif
    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % NREQ);
    endfunction
    always_comb begin
        nxt = reset ? IDLE
            : (rd_req && (!(|wr_req) || wr_streak >= SW'(MAX_WR_BURST))) ? READ
            : (|wr_req) ? WRITE : IDLE;
        idx = '0;
        a_idx = '0;
        b_idx = '0;
        found_a = 1'b0;
        found_b = 1'b0;
        gnt = '0;
`ifdef REGFILE_ARB_PERF_EN
        conflict = 1'b0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            idx = wrap(int'(rr_ptr) + k);
            if (wr_req[idx] && !found_b) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    a_idx = idx;
                end else if (wr_addr[idx*AW +: AW] != wr_addr[a_idx*AW +: AW]) begin
                    found_b = 1'b1;
                    b_idx = idx;
                end
`ifdef REGFILE_ARB_PERF_EN
                else conflict = 1'b1;
`endif
            end
        end
        if (nxt == WRITE) begin
            gnt[a_idx] = 1'b1;
            if (found_b) gnt[b_idx] = 1'b1;
        end
        rr_nxt = (nxt == WRITE) ? wrap(int'(found_b ? b_idx : a_idx) + 1) : rr_ptr;
    end
    assign wr_gnt = gnt;
    assign rd_gnt = (nxt == READ);
    assign rf_w = (state == WRITE);
    assign rf_r = (state == READ);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            wr_streak <= '0;
            rd_valid <= 1'b0;
            rf_write_port <= '0;
            rf_write_port2 <= '0;
            rf_in1 <= '0;
            rf_in2 <= '0;
            rf_read_port1 <= '0;
            rf_read_port2 <= '0;
            rf_read_port3 <= '0;
            rf_read_port4 <= '0;
        end else begin
            state <= nxt;
            rr_ptr <= rr_nxt;
            rd_valid <= (state == READ);
            wr_streak <= (nxt == WRITE && rd_req)
                ? ((wr_streak == SW'(MAX_WR_BURST)) ? wr_streak : wr_streak + 1'b1) : '0;
            if (nxt == WRITE) begin
                rf_write_port <= wr_addr[a_idx*AW +: AW];
                rf_in1 <= wr_data[a_idx*DW +: DW];
                rf_write_port2 <= wr_addr[(found_b ? b_idx : a_idx)*AW +: AW];
                rf_in2 <= wr_data[(found_b ? b_idx : a_idx)*DW +: DW];
            end
            if (nxt == READ) begin
                rf_read_port1 <= rd_addr[0*AW +: AW];
                rf_read_port2 <= rd_addr[1*AW +: AW];
                rf_read_port3 <= rd_addr[2*AW +: AW];
                rf_read_port4 <= rd_addr[3*AW +: AW];
            end
        end
    end
`ifdef REGFILE_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_conflict_cnt <= '0;
            perf_rd_stall_cnt <= '0;
        end else begin
            if (nxt == WRITE && conflict && perf_conflict_cnt != 16'hFFFF)
                perf_conflict_cnt <= perf_conflict_cnt + 16'd1;
            if (rd_req && !rd_gnt && perf_rd_stall_cnt != 16'hFFFF)
                perf_rd_stall_cnt <= perf_rd_stall_cnt + 16'd1;
        end
    end
`endif
endmodule
